// File: rtl/mac_rx_fifo_pkg.sv
// Shared types and constants for the MAC RX store-and-forward frame FIFO.
package mac_rx_fifo_pkg;

    // Width of the frame statistics counters (optional stats build).
    localparam int STATS_WIDTH = 16;

    // Why the write side discarded the frame that just ended.
    typedef enum logic [1:0] {
        DROP_NONE,
        DROP_BAD,
        DROP_OVF
    } drop_reason_t;

    // Pointer width: address bits plus one wrap bit so full and empty differ.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mac_rx_fifo_ram.sv
// Simple dual-port frame storage: synchronous write, asynchronous read.
module mac_rx_fifo_ram #(
    parameter int WIDTH      = 9,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  m_aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store one entry per write-enabled cycle.
    always_ff @(posedge m_aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mac_rx_frame_fifo.sv
// Store-and-forward RX frame FIFO: MAC byte stream in, AXI-Stream beats out.
// Frames are only made visible to the reader once their last byte arrives good;
// bad or overflowing frames are dropped by rewinding the write pointer.
// Optional build macro MAC_RX_FIFO_STATS_EN adds saturating frame counters.
module mac_rx_frame_fifo
    import mac_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096
) (
    input  logic                  m_aclk,
    input  logic                  m_sresetn,
    input  logic [DATA_WIDTH-1:0] s_rx_data,
    input  logic                  s_rx_valid,
    input  logic                  s_rx_last,
    input  logic                  s_rx_bad,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic                  o_drop_bad,
    output logic                  o_drop_ovf
`ifdef MAC_RX_FIFO_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] o_frames_good,
    output logic [STATS_WIDTH-1:0] o_frames_bad,
    output logic [STATS_WIDTH-1:0] o_frames_ovf
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         wr_commit_reg, wr_commit_next;
    logic [PW-1:0]         rd_ptr_reg;
    logic                  ovf_reg, ovf_next;
    logic                  in_sync_reg;
    drop_reason_t          drop_reg, drop_next;
    logic                  full, empty, store, load;
    logic [DATA_WIDTH:0]   rd_data;

    // Full uses the read pointer from before this cycle, so a same-cycle read never helps.
    assign full  = (wr_ptr_reg - rd_ptr_reg) == DEPTH_P;
    assign empty = (rd_ptr_reg == wr_commit_reg);
    assign load  = (!m_axis_tvalid || m_axis_trdy) && !empty;

    mac_rx_fifo_ram #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .m_aclk  (m_aclk),
        .wr_en   (store),
        .wr_addr (wr_ptr_reg[AW-1:0]),
        .wr_data ({s_rx_last, s_rx_data}),
        .rd_addr (rd_ptr_reg[AW-1:0]),
        .rd_data (rd_data)
    );

    // Write side: store bytes, track overflow, commit or rewind at frame end.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        wr_commit_next = wr_commit_reg;
        ovf_next       = ovf_reg;
        drop_next      = DROP_NONE;
        store          = 1'b0;
        if (s_rx_valid && in_sync_reg) begin
            store = !full && !ovf_reg;
            if (s_rx_last) begin
                if (ovf_reg || full) begin
                    // Overflow outranks a bad FCS so a frame yields one pulse only.
                    wr_ptr_next = wr_commit_reg;
                    ovf_next    = 1'b0;
                    drop_next   = DROP_OVF;
                end else if (s_rx_bad) begin
                    wr_ptr_next = wr_commit_reg;
                    drop_next   = DROP_BAD;
                end else begin
                    wr_ptr_next    = wr_ptr_reg + 1'b1;
                    wr_commit_next = wr_ptr_reg + 1'b1;
                end
            end else if (full) begin
                ovf_next = 1'b1;
            end else if (!ovf_reg) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
        end
    end

    // Write-side state; input stays ignored until an idle cycle after reset.
    always_ff @(posedge m_aclk or negedge m_sresetn) begin
        if (!m_sresetn) begin
            wr_ptr_reg    <= '0;
            wr_commit_reg <= '0;
            ovf_reg       <= 1'b0;
            in_sync_reg   <= 1'b0;
            drop_reg      <= DROP_NONE;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            wr_commit_reg <= wr_commit_next;
            ovf_reg       <= ovf_next;
            drop_reg      <= drop_next;
            if (!s_rx_valid) begin
                in_sync_reg <= 1'b1;
            end
        end
    end

    assign o_drop_bad = (drop_reg == DROP_BAD);
    assign o_drop_ovf = (drop_reg == DROP_OVF);

    // Read side: one-deep output register refilled whenever it empties or is accepted.
    always_ff @(posedge m_aclk or negedge m_sresetn) begin
        if (!m_sresetn) begin
            rd_ptr_reg    <= '0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= rd_data[DATA_WIDTH-1:0];
            m_axis_tlast  <= rd_data[DATA_WIDTH];
            m_axis_tvalid <= 1'b1;
            rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        end else if (m_axis_tvalid && m_axis_trdy) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef MAC_RX_FIFO_STATS_EN
    logic [2:0] stat_inc;

    // Index 0: committed frames, 1: bad drops, 2: overflow drops.
    assign stat_inc = {drop_next == DROP_OVF, drop_next == DROP_BAD,
                       wr_commit_next != wr_commit_reg};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        logic [STATS_WIDTH-1:0] cnt_reg;

        // Saturating event counter.
        always_ff @(posedge m_aclk or negedge m_sresetn) begin
            if (!m_sresetn) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi] && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign o_frames_good = g_stat[0].cnt_reg;
    assign o_frames_bad  = g_stat[1].cnt_reg;
    assign o_frames_ovf  = g_stat[2].cnt_reg;
`endif

endmodule

// File: doc/mac_rx_frame_fifo.md
Name: mac_rx_frame_fifo

Overview:
- Store-and-forward frame FIFO between the MAC RX byte stream and the AXI-Stream consumer. The consumer is the UDP/IP RX parser in RTL, and the AXI-Stream RX BFM in simulation.
- Accepts MAC bytes with no backpressure and commits a frame only when its last byte arrives good.
- Frames that end bad, or that overflow the FIFO, are discarded by rewinding the write pointer.
- Committed frames are emitted as AXI-Stream master beats with tlast.

Parameters:
- DATA_WIDTH, 8, width of s_rx_data and m_axis_tdata.
- DEPTH, 4096, number of storage entries; must be a power of 2 and ≥16.

Ports:
- m_aclk  in  1  clock for all logic.
- m_sresetn  in  1  reset, asynchronous, active-low.
- s_rx_data  in  DATA_WIDTH  MAC RX byte.
- s_rx_valid  in  1  byte valid; cannot be stalled.
- s_rx_last  in  1  last byte of frame; qualified by s_rx_valid.
- s_rx_bad  in  1  frame bad (FCS or PHY error); qualified by s_rx_valid & s_rx_last.
- m_axis_tdata  out  DATA_WIDTH  output byte.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tlast  out  1  final beat of frame.
- m_axis_trdy  in  1  downstream ready.
- o_drop_bad  out  1  one-cycle pulse: frame discarded because s_rx_bad was set.
- o_drop_ovf  out  1  one-cycle pulse: frame discarded because of overflow.

Behaviour:
- Reset (async assert, sync release on m_aclk): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_drop_*=0, all pointers=0, ovf flag=0, in_sync=0.
- Pointers: wr_ptr, wr_commit, rd_ptr, each $clog2(DEPTH)+1 bits including a wrap bit.
  - full: wr_ptr - rd_ptr == DEPTH.
  - empty: rd_ptr == wr_commit.
- in_sync:
  - Set on the first cycle with s_rx_valid=0.
  - While in_sync=0, input is ignored. This discards any frame already in progress at reset release.
- Write, on s_rx_valid & in_sync:
  - Not full and ovf=0: store {s_rx_last, s_rx_data} at wr_ptr and increment wr_ptr.
  - Full: set ovf; byte not stored.
  - ovf=1: byte not stored.
- Frame end, on s_rx_valid & s_rx_last & in_sync:
  - Good (s_rx_bad=0, ovf=0, and the last byte was stored): wr_commit <= wr_ptr+1.
  - s_rx_bad=1 (ovf=0): wr_ptr <= wr_commit; o_drop_bad pulses next cycle.
  - Overflow (ovf=1, or the last byte hit full): wr_ptr <= wr_commit; clear ovf; o_drop_ovf pulses next cycle. Overflow takes priority over bad; only one pulse per frame.
- Frames longer than DEPTH always overflow and are dropped.
- Read / output register:
  - Load when (!m_axis_tvalid | m_axis_trdy) & !empty: tdata/tlast <= mem[rd_ptr]; rd_ptr++; tvalid <= 1.
  - When m_axis_tvalid & m_axis_trdy & empty: tvalid <= 0.
  - tdata/tlast hold while tvalid & !trdy.
- Latency: last good byte written in cycle N → commit visible in N+1 → first beat has tvalid=1 in N+2 (FIFO previously empty).
- tvalid stays high from the first beat through the tlast beat of each frame, since the whole frame is resident.
- No beat is lost or duplicated across trdy deassertion.
- Write and read in the same cycle are independent. Full is evaluated with the pre-cycle rd_ptr (conservative).
- Reset mid-frame: both partial output and partial input are discarded; no tlast is owed.

Optional Feature:
- Macro MAC_RX_FIFO_STATS_EN.
- Defined:
  - Adds outputs o_frames_good[15:0], o_frames_bad[15:0], o_frames_ovf[15:0], reset to 0.
  - Each increments on commit, bad drop and overflow drop respectively, saturating at 16'hFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mac_rx_fifo_pkg:
  - Function for pointer width.
  - Enum drop_reason_t {DROP_NONE, DROP_BAD, DROP_OVF}.
  - Stats counter width constant (16).
- Sub-module mac_rx_fifo_ram:
  - Simple dual-port RAM, DEPTH x (DATA_WIDTH+1).
  - Synchronous write, asynchronous read; infers distributed or block RAM.

Test Plan:
- 64-byte good frame, trdy always 1 → 64 beats in order, tlast only on beat 64, first tvalid exactly 2 cycles after the last input byte.
- Good 20-byte frame, then bad 30-byte frame, then good 10-byte frame → output is 20 then 10 bytes, exactly one o_drop_bad pulse, no bad bytes appear.
- DEPTH=16 with a 20-byte frame and trdy=0 → one o_drop_ovf pulse, no output; a following 8-byte frame is delivered intact.
- 100-byte frame with the sink randomly deasserting trdy (~1 in 20 cycles) → all 100 bytes received, tvalid never drops before tlast.
- Assert m_sresetn=0 mid-input and mid-output, release while s_rx_valid is still high → outputs cleared, the in-flight frame is ignored until an idle cycle, and the next frame is delivered correctly.
- 1-byte frames back-to-back with a 1-cycle gap, 50 frames → 50 beats, each with tlast=1.
